// File: rtl/mux_channel_scanner_if.sv
// rtl/mux_channel_scanner_if.sv - control and mux-side signal bundle for the channel scanner
interface mux_channel_scanner_if #(
  parameter int FRAME_CNT_W = 8
);
  logic                   start;
  logic                   continuous;
  logic [3:0]             ch_en;
  logic                   mux_y;
  logic                   S0;
  logic                   S1;
  logic [3:0]             sample;
  logic [3:0]             sample_vld;
  logic                   busy;
  logic                   done;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    output start, continuous, ch_en, mux_y,
    input  S0, S1, sample, sample_vld, busy, done, frame_cnt
  );

  modport slave (
    input  start, continuous, ch_en, mux_y,
    output S0, S1, sample, sample_vld, busy, done, frame_cnt
  );
endinterface

// File: rtl/mux_channel_scanner.sv
// rtl/mux_channel_scanner.sv - steps a 4:1 mux select through enabled channels and captures Y
module mux_channel_scanner #(
  parameter int SETTLE_CYCLES = 2,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  mux_channel_scanner_if.slave      bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t                 state_q;
  logic [3:0]             en_q;
  logic [1:0]             ptr_q;
  logic [3:0]             cnt_q;
  logic [3:0]             sample_q;
  logic [3:0]             vld_q;
  logic                   busy_q;
  logic                   done_q;
  logic [FRAME_CNT_W-1:0] fcnt_q;

  logic [2:0]             first_ch;
  logic [2:0]             next_ch;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] scan_from(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  always_comb begin
    first_ch = scan_from(bus.ch_en, 3'd0);
    next_ch  = scan_from(en_q, {1'b0, ptr_q} + 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 4'b0000;
      ptr_q    <= 2'b00;
      cnt_q    <= 4'd0;
      sample_q <= 4'b0000;
      vld_q    <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start && (bus.ch_en != 4'b0000)) begin
            en_q    <= bus.ch_en;
            vld_q   <= 4'b0000;
            busy_q  <= 1'b1;
            ptr_q   <= first_ch[1:0];
            cnt_q   <= 4'd0;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= 4'd0;
            state_q <= ST_CAPTURE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_CAPTURE: begin
          sample_q[ptr_q] <= bus.mux_y;
          vld_q[ptr_q]    <= 1'b1;
          if (next_ch[2]) begin
            ptr_q   <= next_ch[1:0];
            state_q <= ST_SETTLE;
          end else begin
            done_q <= 1'b1;
            fcnt_q <= fcnt_q + FRAME_CNT_W'(1);
            // Back-to-back frame: the clear of sample_vld overrides the final capture flag.
            if (bus.continuous && (bus.ch_en != 4'b0000)) begin
              en_q    <= bus.ch_en;
              vld_q   <= 4'b0000;
              ptr_q   <= first_ch[1:0];
              state_q <= ST_SETTLE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.S0         = ptr_q[0];
  assign bus.S1         = ptr_q[1];
  assign bus.sample     = sample_q;
  assign bus.sample_vld = vld_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// tb/tb_mux_channel_scanner.sv - randomized scoreboard bench for mux_channel_scanner
module tb_mux_channel_scanner;

  localparam int S  = 2;
  localparam int FW = 8;

  typedef struct {
    logic [3:0]    smp;
    logic [3:0]    vld;
    logic [FW-1:0] fcnt;
    int            cum;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] din;

  mux_channel_scanner_if #(.FRAME_CNT_W(FW)) bus ();

  mux_channel_scanner #(.SETTLE_CYCLES(S), .FRAME_CNT_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mux_y = din[{bus.S1, bus.S0}];

  int tests = 0;
  int fails = 0;

  rec_t          frame_q[$];
  int            sel_q[$];
  logic [3:0]    plan[$];
  logic [3:0]    m_sample = 4'b0000;
  logic [FW-1:0] m_fcnt = '0;
  int            m_cum = 0;
  int            busy_cnt = 0;
  rec_t          mon_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int flen(input logic [3:0] mask);
    return ($countones(mask)) * (S + 1);
  endfunction

  task automatic push_frame(input logic [3:0] mask, input bit cont);
    rec_t r;
    for (int ch = 0; ch < 4; ch++) begin
      if (mask[ch]) begin
        for (int k = 0; k < S + 1; k++) sel_q.push_back(ch);
      end
    end
    m_cum    += flen(mask);
    m_sample  = (m_sample & ~mask) | (din & mask);
    m_fcnt    = m_fcnt + 1'b1;
    r.smp  = m_sample;
    r.vld  = cont ? 4'b0000 : mask;
    r.fcnt = m_fcnt;
    r.cum  = m_cum;
    frame_q.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_S0"}, 32'(bus.S0), 0);
    check({tag, "_S1"}, 32'(bus.S1), 0);
    check({tag, "_sample"}, 32'(bus.sample), 0);
    check({tag, "_sample_vld"}, 32'(bus.sample_vld), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 0);
  endtask

  // Runs the frames in 'plan' back to back; mask i+1 is presented mid-frame i.
  task automatic run_frames(input bit poke);
    int n;
    int len;
    n = plan.size();
    for (int i = 0; i < n; i++) push_frame(plan[i], i < n - 1);
    bus.ch_en      = plan[0];
    bus.continuous = (n > 1);
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      len = flen(plan[i]);
      bus.ch_en = (i < n - 1) ? plan[i+1] : plan[i];
      if (i == n - 1) bus.continuous = 1'b0;
      if (poke) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (len - 2) begin
        @(posedge clk); #1;
      end
      if (poke && i == n - 1) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (frame_q.size() == 0) begin
          check("spurious_done", 32'(bus.done), 0);
        end else begin
          mon_r = frame_q.pop_front();
          check("frame_sample", 32'(bus.sample), 32'(mon_r.smp));
          check("frame_sample_vld", 32'(bus.sample_vld), 32'(mon_r.vld));
          check("frame_cnt", 32'(bus.frame_cnt), 32'(mon_r.fcnt));
          check("busy_cycles", busy_cnt, mon_r.cum);
        end
      end
      if (bus.busy) begin
        if (sel_q.size() == 0) check("extra_busy", 32'(bus.busy), 0);
        else check("select", 32'({bus.S1, bus.S0}), sel_q.pop_front());
        busy_cnt++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    din = 4'b0000;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.ch_en = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    din = 4'b1101;
    plan = '{4'b1111};
    run_frames(1'b0);

    din = 4'b0010;
    plan = '{4'b1010};
    run_frames(1'b1);

    din = 4'(($urandom));
    plan = '{4'b0001, 4'b0100, 4'b0100};
    run_frames(1'b1);

    bus.ch_en = 4'b0000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_done", 32'(bus.done), 0);
    check("idle_frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));

    for (int t = 0; t < 4; t++) begin
      din = 4'($urandom);
      plan = '{4'($urandom_range(1, 15))};
      run_frames(t[0]);
    end

    din = 4'($urandom);
    plan.delete();
    for (int t = 0; t < 5; t++) plan.push_back(4'($urandom_range(1, 15)));
    run_frames(1'b1);

    din = 4'($urandom);
    push_frame(4'b1111, 1'b0);
    bus.ch_en = 4'b1111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sel_q.delete();
    frame_q.delete();
    m_sample = 4'b0000;
    m_fcnt = '0;
    m_cum = 0;
    busy_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midframe_reset");
    repeat (3) begin
      @(posedge clk); #1;
    end

    din = 4'($urandom);
    plan.delete();
    for (int t = 0; t < 256; t++) plan.push_back(4'($urandom_range(1, 15)));
    run_frames(1'b0);
    check("wrap_frame_cnt", 32'(bus.frame_cnt), 0);
    check("wrap_busy", 32'(bus.busy), 0);

    check("sel_queue_drained", sel_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
